mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single external memory port between the instruction-fetch requester (imem) and the load/store requester (dmem). Requests are accepted one at a time, re-driven on the memory side, and the response is routed back to its owner. It sits between the DataPath's imem/dmem request bundles and the memory bus, and also supplies the per-requester wait signals that feed the cache-stall input of the control path.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte mask width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive dmem grants allowed while imem waits (range 1..15).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  in  1  fetch request.
- imem_req_addr  in  ADDR_W  fetch address.
- imem_req_ready  out  1  fetch request accepted this cycle.
- imem_resp_valid  out  1  fetch data valid (one-cycle pulse).
- imem_resp_data  out  DATA_W  fetch data.
- dmem_req_valid  in  1  load/store request.
- dmem_req_addr  in  ADDR_W  load/store address.
- dmem_req_wen  in  1  1 = store, 0 = load.
- dmem_req_wdata  in  DATA_W  store data.
- dmem_req_wmask  in  DATA_W/8  store byte enables.
- dmem_req_ready  out  1  load/store request accepted this cycle.
- dmem_resp_valid  out  1  load data / store ack valid (one-cycle pulse).
- dmem_resp_data  out  DATA_W  load data.
- mem_req_valid  out  1  memory request.
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  memory request fields.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  memory response.
- mem_resp_data  in  DATA_W  memory response data.
- imem_wait, dmem_wait  out  1  requester has valid request not accepted this cycle (combinational: valid && !ready).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One transaction outstanding at most.
- IDLE: if any request valid, grant one; assert that requester's ready for that cycle; latch addr/wen/wdata/wmask and owner bit; go ISSUE. Otherwise stay.
- Grant rule: dmem wins over imem; see Configuration for starvation guard. Only one ready asserted per cycle.
- ISSUE: mem_req_valid=1 with latched fields, held stable; on mem_req_ready go WAIT.
- WAIT: on mem_resp_valid latch mem_resp_data, go RESP.
- RESP: owner's resp_valid=1 and resp_data=latched data for exactly one cycle; go IDLE. Store responses return whatever memory supplied; dmem ignores data on stores.
- imem request fields are forwarded with mem_req_wen=0, wdata=0, wmask=0.
- mem_resp_valid outside WAIT is ignored (no state change, no forwarding).
- req_ready is low in ISSUE, WAIT, RESP; requesters hold valid and fields until ready.

## Timing
- Reset (async assert, sync-to-clk release): state=IDLE, all valid/ready outputs 0, all data/addr outputs 0, owner=imem, starvation counter 0. Reset in any state abandons the transaction; a late mem_resp_valid after reset is dropped.
- Accept at cycle N → mem_req_valid from N+1. If mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid at N+3. Minimum 4 cycles per transaction; next accept earliest N+4.
- Backpressure: each cycle of mem_req_ready=0 or mem_resp_valid=0 adds one cycle.
- Simultaneous imem and dmem valid in IDLE: grant per rule; loser sees *_wait=1 and keeps waiting.

## Configuration
- MEM_PORT_ARB_STARVE_GUARD_EN defined: 4-bit counter increments on each dmem grant made while imem_req_valid=1, clears on any imem grant or when imem_req_valid=0 in IDLE. When counter == STARVE_LIMIT and both valid, imem is granted.
- Not defined: strict dmem priority, no counter; imem may starve indefinitely.

## Test plan
- Single fetch: imem valid addr 0x100, mem ready immediately, resp 0xDEADBEEF one cycle after issue → imem_resp_valid at accept+3 with 0xDEADBEEF; dmem_resp_valid stays 0.
- Store: dmem wen=1 addr 0x200 wdata 0x12345678 wmask 0xF → mem_req fields match exactly; dmem_resp_valid one pulse.
- Collision: both valid in same IDLE cycle → dmem accepted first, imem_wait=1 until imem accepted at the next IDLE.
- Starvation (macro on, STARVE_LIMIT=4): dmem and imem valid continuously → grants D,D,D,D,I,D,...; macro off → imem never granted.
- Backpressure: mem_req_ready low 3 cycles then high, resp after 2 more → mem_req fields stable throughout, resp_valid exactly once.
- Reset in WAIT, then mem_resp_valid pulses after release → no resp_valid on either side, state IDLE, next request handled normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the instruction
// fetch requester (imem) and the load/store requester (dmem). Only one
// transaction is outstanding at a time. The FSM runs IDLE -> ISSUE -> WAIT -> RESP.
// dmem has priority over imem.
// Optional starvation guard: define MEM_PORT_ARB_STARVE_GUARD_EN. With it, imem
// is granted after STARVE_LIMIT consecutive dmem grants made while imem waited.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_req_valid,
  input  logic [ADDR_W-1:0]   imem_req_addr,
  output logic                imem_req_ready,
  output logic                imem_resp_valid,
  output logic [DATA_W-1:0]   imem_resp_data,
  input  logic                dmem_req_valid,
  input  logic [ADDR_W-1:0]   dmem_req_addr,
  input  logic                dmem_req_wen,
  input  logic [DATA_W-1:0]   dmem_req_wdata,
  input  logic [DATA_W/8-1:0] dmem_req_wmask,
  output logic                dmem_req_ready,
  output logic                dmem_resp_valid,
  output logic [DATA_W-1:0]   dmem_resp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                imem_wait,
  output logic                dmem_wait
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner_d;   // 1 = current transaction belongs to dmem
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_force_i;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  // Force an imem grant once dmem has won LIMIT times in a row over a waiting imem
  assign w_force_i = (r_starve_cnt == LIMIT) && imem_req_valid && dmem_req_valid;

  // Count dmem grants taken while imem was waiting; clear when imem is served or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_i || !imem_req_valid) begin
        r_starve_cnt <= 4'd0;
      end else if (w_grant_d && (r_starve_cnt != 4'hF)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, grant and handshake outputs
  always_comb begin
    w_next          = r_state;
    w_grant_d       = 1'b0;
    w_grant_i       = 1'b0;
    imem_req_ready  = 1'b0;
    dmem_req_ready  = 1'b0;
    mem_req_valid   = 1'b0;
    imem_resp_valid = 1'b0;
    dmem_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_d      = dmem_req_valid && !w_force_i;
        w_grant_i      = imem_req_valid && !w_grant_d;
        dmem_req_ready = w_grant_d;
        imem_req_ready = w_grant_i;
        if (w_grant_d || w_grant_i) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        dmem_resp_valid = r_owner_d;
        imem_resp_valid = !r_owner_d;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the granted request and the memory response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_d <= 1'b0;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_grant_d) begin
        r_owner_d <= 1'b1;
        r_addr    <= dmem_req_addr;
        r_wen     <= dmem_req_wen;
        r_wdata   <= dmem_req_wdata;
        r_wmask   <= dmem_req_wmask;
      end else if (w_grant_i) begin
        // Fetches are always reads: write fields are forced to zero
        r_owner_d <= 1'b0;
        r_addr    <= imem_req_addr;
        r_wen     <= 1'b0;
        r_wdata   <= '0;
        r_wmask   <= '0;
      end
      if ((r_state == S_WAIT) && mem_resp_valid) begin
        r_rdata <= mem_resp_data;
      end
    end
  end

  assign mem_req_addr   = r_addr;
  assign mem_req_wen    = r_wen;
  assign mem_req_wdata  = r_wdata;
  assign mem_req_wmask  = r_wmask;
  assign imem_resp_data = imem_resp_valid ? r_rdata : '0;
  assign dmem_resp_data = dmem_resp_valid ? r_rdata : '0;
  assign imem_wait      = imem_req_valid && !imem_req_ready;
  assign dmem_wait      = dmem_req_valid && !dmem_req_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a table of single transactions,
// then hand-written collision, starvation and reset-in-WAIT sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid = 1'b0;
  logic [31:0] imem_req_addr = '0;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dmem_req_valid = 1'b0;
  logic [31:0] dmem_req_addr = '0;
  logic        dmem_req_wen = 1'b0;
  logic [31:0] dmem_req_wdata = '0;
  logic [3:0]  dmem_req_wmask = '0;
  logic        dmem_req_ready;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        imem_wait;
  logic        dmem_wait;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wen(dmem_req_wen), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_wmask(dmem_req_wmask), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    int          e_lat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One complete transaction from table entry i
  task automatic run_txn(input int i);
    vec_t v;
    bit got;
    int unsigned c0;
    v = vt[i];
    @(negedge clk);
    imem_req_valid = !v.is_d;
    dmem_req_valid = v.is_d;
    imem_req_addr  = v.addr;
    dmem_req_addr  = v.addr;
    dmem_req_wen   = v.wen;
    dmem_req_wdata = v.wdata;
    dmem_req_wmask = v.wmask;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (v.is_d ? dmem_req_ready : imem_req_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("v%0d accept", i), 32'(got), 32'd1);
    chk($sformatf("v%0d other_ready", i), 32'(v.is_d ? imem_req_ready : dmem_req_ready), 32'd0);
    c0 = cyc;
    @(negedge clk);
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    for (int k = 0; k <= v.rdy_dly; k++) begin
      chk($sformatf("v%0d mreq_valid", i), 32'(mem_req_valid), 32'd1);
      chk($sformatf("v%0d mreq_addr", i), mem_req_addr, v.e_addr);
      chk($sformatf("v%0d mreq_wen", i), 32'(mem_req_wen), 32'(v.e_wen));
      chk($sformatf("v%0d mreq_wdata", i), mem_req_wdata, v.e_wdata);
      chk($sformatf("v%0d mreq_wmask", i), 32'(mem_req_wmask), 32'(v.e_wmask));
      mem_req_ready = (k == v.rdy_dly);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    for (int j = 0; j <= v.rsp_dly; j++) begin
      chk($sformatf("v%0d mreq_drop", i), 32'(mem_req_valid), 32'd0);
      mem_resp_valid = (j == v.rsp_dly);
      mem_resp_data  = (j == v.rsp_dly) ? v.rdata : (32'h5A5A0000 | 32'(j));
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'hFFFF_0000;
    chk($sformatf("v%0d resp_valid", i), 32'(v.is_d ? dmem_resp_valid : imem_resp_valid), 32'd1);
    chk($sformatf("v%0d resp_data", i), v.is_d ? dmem_resp_data : imem_resp_data, v.rdata);
    chk($sformatf("v%0d other_resp", i), 32'(v.is_d ? imem_resp_valid : dmem_resp_valid), 32'd0);
    chk($sformatf("v%0d latency", i), 32'(cyc - c0), 32'(v.e_lat));
    @(negedge clk);
    chk($sformatf("v%0d resp_pulse_end", i), 32'(imem_resp_valid | dmem_resp_valid), 32'd0);
  endtask

  initial begin
    logic exp_i;
    // is_d addr wen wdata wmask rdata rdy rsp | e_addr e_wen e_wdata e_wmask e_lat
    vt[0] = '{1'b0, 32'h100, 1'b1, 32'hAAAA5555, 4'hF, 32'hDEADBEEF, 0, 0,
              32'h100, 1'b0, 32'h0, 4'h0, 3};
    vt[1] = '{1'b1, 32'h200, 1'b1, 32'h12345678, 4'hF, 32'h00000000, 0, 0,
              32'h200, 1'b1, 32'h12345678, 4'hF, 3};
    vt[2] = '{1'b1, 32'h304, 1'b0, 32'h00000000, 4'h0, 32'hCAFEF00D, 0, 0,
              32'h304, 1'b0, 32'h0, 4'h0, 3};
    vt[3] = '{1'b0, 32'h400, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0BADC0DE, 3, 2,
              32'h400, 1'b0, 32'h0, 4'h0, 8};
    vt[4] = '{1'b1, 32'h500, 1'b1, 32'hA5A55A5A, 4'h6, 32'h11111111, 1, 1,
              32'h500, 1'b1, 32'hA5A55A5A, 4'h6, 5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst mreq_valid", 32'(mem_req_valid), 32'd0);
    chk("rst mreq_addr", mem_req_addr, 32'd0);
    chk("rst mreq_wdata", mem_req_wdata, 32'd0);
    chk("rst resp_valid", 32'({imem_resp_valid, dmem_resp_valid}), 32'd0);
    chk("rst resp_data", imem_resp_data | dmem_resp_data, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(i);

    // Collision: dmem first, imem waits, then imem served at next IDLE
    @(negedge clk);
    imem_req_valid = 1'b1; imem_req_addr = 32'h600;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h700; dmem_req_wen = 1'b0;
    dmem_req_wdata = 32'h0; dmem_req_wmask = 4'h0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h42;
    #1;
    chk("col dmem_ready", 32'(dmem_req_ready), 32'd1);
    chk("col imem_ready", 32'(imem_req_ready), 32'd0);
    chk("col imem_wait", 32'(imem_wait), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        dmem_req_valid = 1'b0;
        chk("col mreq_addr_d", mem_req_addr, 32'h700);
      end
      #1;
      chk($sformatf("col imem_wait_%0d", k), 32'(imem_wait), 32'd1);
    end
    chk("col dmem_resp", 32'(dmem_resp_valid), 32'd1);
    @(negedge clk);
    #1;
    chk("col imem_ready2", 32'(imem_req_ready), 32'd1);
    chk("col imem_wait2", 32'(imem_wait), 32'd0);
    @(negedge clk);
    imem_req_valid = 1'b0;
    chk("col mreq_addr_i", mem_req_addr, 32'h600);
    chk("col mreq_wen_i", 32'(mem_req_wen), 32'd0);
    repeat (2) @(negedge clk);
    chk("col imem_resp", 32'(imem_resp_valid), 32'd1);
    chk("col imem_data", imem_resp_data, 32'h42);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);

    // Starvation: both requesters valid continuously
    imem_req_valid = 1'b1; imem_req_addr = 32'h800;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h900;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    for (int g = 0; g < 6; g++) begin
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
      exp_i = (g == 4);
`else
      exp_i = 1'b0;
`endif
      #1;
      chk($sformatf("starve imem_grant_%0d", g), 32'(imem_req_ready), 32'(exp_i));
      chk($sformatf("starve dmem_grant_%0d", g), 32'(dmem_req_ready), 32'(!exp_i));
      repeat (4) @(negedge clk);
    end
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

    // Reset while in WAIT, then a late memory response
    @(negedge clk);
    dmem_req_valid = 1'b1; dmem_req_addr = 32'hA00; dmem_req_wen = 1'b0;
    #1;
    chk("rw accept", 32'(dmem_req_ready), 32'd1);
    @(negedge clk);
    dmem_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rw in_wait", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw rst_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) mem_resp_valid = 1'b0;
      chk($sformatf("rw no_resp_%0d", k), 32'({imem_resp_valid, dmem_resp_valid}), 32'd0);
      chk($sformatf("rw no_mreq_%0d", k), 32'(mem_req_valid), 32'd0);
    end
    run_txn(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
